// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR sequencer: FSM state encoding,
// default sizing and a counter-width helper.
package lfsr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WARM  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int DEF_N      = 20;
  localparam int DEF_STRIDE = 20;
  localparam int DEF_WARMUP = 20;
  localparam int DEF_CNT_W  = 8;
  localparam int OVR_W      = 8;

  // Bits needed to hold the values 0 .. max_count-1 (never less than one).
  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Bus between the sequencer, the attached LFSR and the word consumer:
// LFSR control/state plus the valid/ready output stream.
interface lfsr_seq_ctrl_if #(
  parameter int N = 20
);

  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         lfsr_r;
  logic         lfsr_load;
  logic [3:0]   lfsr_s;
  logic [N-1:0] lfsr_q;

  modport master (
    output out_data,
    output out_valid,
    output lfsr_r,
    output lfsr_load,
    output lfsr_s,
    input  out_ready,
    input  lfsr_q
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  lfsr_r,
    input  lfsr_load,
    input  lfsr_s,
    output out_ready,
    output lfsr_q
  );

endinterface

// File: rtl/lfsr_word_buf.sv
// One-entry valid/ready holding register. A capture is either accepted
// (slot free or emptying this cycle) or dropped; both are reported back.
module lfsr_word_buf
  import lfsr_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         r,
  input  logic         i_capture,
  input  logic         i_clear,
  input  logic [N-1:0] i_data,
  input  logic         i_ready,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  output logic         o_accept,
  output logic         o_drop
);

  logic [N-1:0] r_data;
  logic         r_valid;
  logic         w_draining;

  assign w_draining = r_valid & i_ready;
  assign o_accept   = i_capture & (~r_valid | i_ready);
  assign o_drop     = i_capture & r_valid & ~i_ready;
  assign o_data     = r_data;
  assign o_valid    = r_valid;

  // Clear wins over everything; a fresh capture may replace a word leaving this cycle.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (o_accept) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (w_draining) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for a free-running LFSR: clear, seed-load, warm-up, then sample
// every STRIDE cycles and hand num_words samples to one consumer.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int STRIDE = DEF_STRIDE,
  parameter int WARMUP = DEF_WARMUP,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             r,
  input  logic             i_start,
  input  logic [3:0]       i_seed,
  input  logic [CNT_W-1:0] i_num_words,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err_zero,
  output logic [OVR_W-1:0] o_overrun_cnt,
  lfsr_seq_ctrl_if.master  bus
);

  localparam int CW = cnt_width((WARMUP > STRIDE) ? WARMUP : STRIDE);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_words_left;
  logic             r_busy;
  logic             r_done;
  logic             r_err_zero;
  logic [OVR_W-1:0] r_ovr;
  logic             r_lfsr_r;
  logic             r_lfsr_load;
  logic [3:0]       r_lfsr_s;

  logic             w_abort;
  logic             w_sample;
  logic             w_zero;
  logic             w_capture;
  logic             w_clear;
  logic             w_accept;
  logic             w_drop;
  logic [N-1:0]     w_buf_data;
  logic             w_buf_valid;

  // The LFSR cannot be stalled, so abort has to beat a sample that lands this cycle.
  assign w_abort   = i_abort & (r_state != IDLE);
  assign w_sample  = (r_state == RUN) & (r_cnt == '0) & ~i_abort;
  assign w_zero    = (bus.lfsr_q == '0);
  assign w_capture = w_sample & ~w_zero;
  assign w_clear   = w_abort | (w_sample & w_zero);

  lfsr_word_buf #(
    .N (N)
  ) u_buf (
    .clk       (clk),
    .r         (r),
    .i_capture (w_capture),
    .i_clear   (w_clear),
    .i_data    (bus.lfsr_q),
    .i_ready   (bus.out_ready),
    .o_data    (w_buf_data),
    .o_valid   (w_buf_valid),
    .o_accept  (w_accept),
    .o_drop    (w_drop)
  );

  assign bus.out_data   = w_buf_data;
  assign bus.out_valid  = w_buf_valid;
  assign bus.lfsr_r     = r_lfsr_r;
  assign bus.lfsr_load  = r_lfsr_load;
  assign bus.lfsr_s     = r_lfsr_s;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err_zero     = r_err_zero;
  assign o_overrun_cnt  = r_ovr;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_words_left <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_zero   <= 1'b0;
      r_ovr        <= '0;
      r_lfsr_r     <= 1'b1;
      r_lfsr_load  <= 1'b0;
      r_lfsr_s     <= '0;
    end else begin
      r_done      <= 1'b0;
      r_lfsr_load <= 1'b0;
      if (w_abort) begin
        r_state  <= IDLE;
        r_busy   <= 1'b0;
        r_lfsr_r <= 1'b1;
        r_lfsr_s <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start) begin
              if (i_seed == 4'd0) begin
                r_err_zero <= 1'b1;
              end else if (i_num_words == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state      <= LOAD;
                r_busy       <= 1'b1;
                r_words_left <= i_num_words;
                r_err_zero   <= 1'b0;
                r_ovr        <= '0;
                r_lfsr_r     <= 1'b0;
                r_lfsr_load  <= 1'b1;
                r_lfsr_s     <= i_seed;
              end
            end
          end

          LOAD: begin
            r_state <= WARM;
            r_cnt   <= CW'(WARMUP - 1);
          end

          WARM: begin
            if (r_cnt == '0) begin
              r_state <= RUN;
              r_cnt   <= CW'(STRIDE - 1);
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end

          RUN: begin
            if (r_cnt == '0) begin
              r_cnt <= CW'(STRIDE - 1);
              if (w_zero) begin
                // A zero sample means the LFSR has locked up; stop without done.
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_err_zero <= 1'b1;
                r_lfsr_r   <= 1'b1;
                r_lfsr_s   <= '0;
              end else if (w_accept) begin
                r_words_left <= r_words_left - 1'b1;
                if (r_words_left == CNT_W'(1)) begin
                  r_state <= DRAIN;
                end
              end else if (w_drop && (r_ovr != '1)) begin
                r_ovr <= r_ovr + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end

          DRAIN: begin
            if (w_buf_valid && bus.out_ready) begin
              r_state  <= IDLE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_lfsr_r <= 1'b1;
              r_lfsr_s <= '0;
            end
          end

          default: begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_lfsr_r <= 1'b1;
            r_lfsr_s <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: attaches a 20-bit Fibonacci LFSR (x^20+x^17+1)
// and checks delivered words against a scoreboard of expected samples.
module tb_lfsr_seq_ctrl;
  import lfsr_pkg::*;

  localparam int N           = DEF_N;
  localparam int STRIDE      = DEF_STRIDE;
  localparam int WARMUP      = DEF_WARMUP;
  localparam int CNT_W       = DEF_CNT_W;
  localparam int FIRST_STEPS = WARMUP + STRIDE - 1;
  localparam int LATENCY     = 1 + WARMUP + STRIDE;

  typedef struct {
    logic [3:0]       seed;
    logic [CNT_W-1:0] numWords;
    bit               expErr;
    int               expDone;
    int               expLoads;
    bit               expBusy;
  } vec_t;

  logic             clk = 1'b0;
  logic             r = 1'b0;
  logic             i_start = 1'b0;
  logic [3:0]       i_seed = '0;
  logic [CNT_W-1:0] i_num_words = '0;
  logic             i_abort = 1'b0;
  logic             o_busy;
  logic             o_done;
  logic             o_err_zero;
  logic [OVR_W-1:0] o_overrun_cnt;

  lfsr_seq_ctrl_if #(.N(N)) bus ();

  lfsr_seq_ctrl #(
    .N      (N),
    .STRIDE (STRIDE),
    .WARMUP (WARMUP),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .r             (r),
    .i_start       (i_start),
    .i_seed        (i_seed),
    .i_num_words   (i_num_words),
    .i_abort       (i_abort),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err_zero    (o_err_zero),
    .o_overrun_cnt (o_overrun_cnt),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] lfsrNext(input logic [N-1:0] s);
    return {s[N-2:0], s[19] ^ s[16]};
  endfunction

  function automatic logic [N-1:0] lfsrAfter(input logic [3:0] seed, input int steps);
    logic [N-1:0] s;
    s = {{(N-4){1'b0}}, seed};
    for (int i = 0; i < steps; i++) s = lfsrNext(s);
    return s;
  endfunction

  // The attached LFSR: synchronous clear, seed load, otherwise free-running.
  logic [N-1:0] lfsrState = '0;
  always @(posedge clk) begin
    if (bus.lfsr_r)         lfsrState <= '0;
    else if (bus.lfsr_load) lfsrState <= {{(N-4){1'b0}}, bus.lfsr_s};
    else                    lfsrState <= lfsrNext(lfsrState);
  end
  assign bus.lfsr_q = lfsrState;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           doneCnt = 0;
  int           loadCnt = 0;
  int           xferCnt = 0;
  int           doneCyc = -1;
  int           firstValidCyc = -1;
  int           acceptCyc = 0;
  int           doneBase, loadBase, xferBase;
  bit           busySeen = 1'b0;
  bit           prevHold = 1'b0;
  logic [N-1:0] prevData = '0;
  logic [N-1:0] expQ[$];
  int           xferCycQ[$];
  vec_t         vecs[3];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Observe at the falling edge, then return just after the next rising edge.
  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    if (o_done) begin
      doneCnt++;
      doneCyc = cyc;
    end
    if (bus.lfsr_load) loadCnt++;
    if (o_busy) busySeen = 1'b1;
    if (bus.out_valid && firstValidCyc < 0) firstValidCyc = cyc;
    if (prevHold && bus.out_valid) checkOutput("data_stable", 64'(bus.out_data), 64'(prevData));
    if (bus.out_valid && bus.out_ready) begin
      xferCnt++;
      xferCycQ.push_back(cyc);
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_word: got=%0h expected=none", bus.out_data);
      end else begin
        checkOutput("word", 64'(bus.out_data), 64'(expQ.pop_front()));
      end
    end
    prevHold = bus.out_valid && !bus.out_ready;
    prevData = bus.out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic resetCounters();
    firstValidCyc = -1;
    busySeen      = 1'b0;
    xferCycQ.delete();
    doneBase = doneCnt;
    loadBase = loadCnt;
    xferBase = xferCnt;
  endtask

  task automatic applyStimulus(input logic [3:0] seed, input logic [CNT_W-1:0] nw);
    i_seed      = seed;
    i_num_words = nw;
    i_start     = 1'b1;
    stepCycle();
    acceptCyc = cyc;
    i_start   = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles);
    int d0;
    d0 = doneCnt;
    for (int i = 0; i < maxCycles && doneCnt == d0; i++) stepCycle();
    checkOutput("done_seen", 64'(doneCnt - d0), 64'd1);
  endtask

  task automatic waitValid(input int maxCycles);
    for (int i = 0; i < maxCycles && !bus.out_valid; i++) stepCycle();
    checkOutput("valid_seen", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic runBasic();
    bus.out_ready = 1'b1;
    resetCounters();
    for (int i = 0; i < 3; i++) expQ.push_back(lfsrAfter(4'b1000, FIRST_STEPS + STRIDE * i));
    applyStimulus(4'b1000, CNT_W'(3));
    waitDone(150);
    runCycles(3);
    checkOutput("latency", 64'(firstValidCyc - acceptCyc - 1), 64'(LATENCY));
    checkOutput("xfers", 64'(xferCnt - xferBase), 64'd3);
    if (xferCycQ.size() == 3) begin
      checkOutput("spacing1", 64'(xferCycQ[1] - xferCycQ[0]), 64'(STRIDE));
      checkOutput("spacing2", 64'(xferCycQ[2] - xferCycQ[1]), 64'(STRIDE));
      checkOutput("done_after_last", 64'(doneCyc - xferCycQ[2]), 64'd1);
    end
    checkOutput("done_once", 64'(doneCnt - doneBase), 64'd1);
    checkOutput("loads", 64'(loadCnt - loadBase), 64'd1);
    checkOutput("overrun_basic", 64'(o_overrun_cnt), 64'd0);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("busy_end", 64'(o_busy), 64'd0);
    expQ.delete();
  endtask

  initial begin
    vecs[0] = '{seed: 4'h3, numWords: CNT_W'(0), expErr: 1'b0, expDone: 1, expLoads: 0, expBusy: 1'b0};
    vecs[1] = '{seed: 4'h0, numWords: CNT_W'(5), expErr: 1'b1, expDone: 0, expLoads: 0, expBusy: 1'b0};
    vecs[2] = '{seed: 4'h0, numWords: CNT_W'(1), expErr: 1'b1, expDone: 0, expLoads: 0, expBusy: 1'b0};
    bus.out_ready = 1'b1;

    // Reset values while r is held low.
    runCycles(3);
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_done", 64'(o_done), 64'd0);
    checkOutput("rst_err", 64'(o_err_zero), 64'd0);
    checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_data", 64'(bus.out_data), 64'd0);
    checkOutput("rst_ovr", 64'(o_overrun_cnt), 64'd0);
    checkOutput("rst_lfsr_s", 64'(bus.lfsr_s), 64'd0);
    checkOutput("rst_lfsr_r", 64'(bus.lfsr_r), 64'd1);
    checkOutput("rst_lfsr_load", 64'(bus.lfsr_load), 64'd0);
    r = 1'b1;
    runCycles(2);

    // Starts that must stay in IDLE.
    for (int v = 0; v < 3; v++) begin
      resetCounters();
      applyStimulus(vecs[v].seed, vecs[v].numWords);
      runCycles(4);
      checkOutput("vec_err", 64'(o_err_zero), 64'(vecs[v].expErr));
      checkOutput("vec_done", 64'(doneCnt - doneBase), 64'(vecs[v].expDone));
      checkOutput("vec_loads", 64'(loadCnt - loadBase), 64'(vecs[v].expLoads));
      checkOutput("vec_busy", 64'(busySeen), 64'(vecs[v].expBusy));
    end

    // A good seed clears the sticky zero error and runs one word.
    resetCounters();
    expQ.push_back(lfsrAfter(4'b0001, FIRST_STEPS));
    applyStimulus(4'b0001, CNT_W'(1));
    checkOutput("err_cleared", 64'(o_err_zero), 64'd0);
    waitDone(100);
    checkOutput("one_word_queue", 64'(expQ.size()), 64'd0);
    expQ.delete();
    runCycles(2);

    runBasic();

    // Back-pressure: two samples arrive while the buffer is stuck full.
    bus.out_ready = 1'b0;
    resetCounters();
    expQ.push_back(lfsrAfter(4'b1000, FIRST_STEPS));
    expQ.push_back(lfsrAfter(4'b1000, FIRST_STEPS + 3 * STRIDE));
    applyStimulus(4'b1000, CNT_W'(2));
    waitValid(100);
    runCycles(45);
    bus.out_ready = 1'b1;
    waitDone(150);
    checkOutput("bp_overrun", 64'(o_overrun_cnt), 64'd2);
    checkOutput("bp_queue", 64'(expQ.size()), 64'd0);
    checkOutput("bp_done", 64'(doneCnt - doneBase), 64'd1);
    expQ.delete();
    runCycles(2);

    // Abort five cycles into RUN, with a start issued mid-run.
    resetCounters();
    applyStimulus(4'b1000, CNT_W'(3));
    runCycles(WARMUP + 5);
    i_seed      = 4'h2;
    i_num_words = CNT_W'(1);
    i_start     = 1'b1;
    stepCycle();
    i_start = 1'b0;
    i_abort = 1'b1;
    stepCycle();
    i_abort = 1'b0;
    checkOutput("abort_busy", 64'(o_busy), 64'd0);
    checkOutput("abort_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort_lfsr_r", 64'(bus.lfsr_r), 64'd1);
    runCycles(60);
    checkOutput("abort_no_done", 64'(doneCnt - doneBase), 64'd0);
    checkOutput("abort_no_xfer", 64'(xferCnt - xferBase), 64'd0);
    checkOutput("abort_loads", 64'(loadCnt - loadBase), 64'd1);

    // Asynchronous reset while a word is waiting.
    bus.out_ready = 1'b0;
    resetCounters();
    applyStimulus(4'b1000, CNT_W'(3));
    waitValid(100);
    #3;
    r = 1'b0;
    #1;
    checkOutput("areset_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("areset_busy", 64'(o_busy), 64'd0);
    checkOutput("areset_lfsr_r", 64'(bus.lfsr_r), 64'd1);
    checkOutput("areset_data", 64'(bus.out_data), 64'd0);
    checkOutput("areset_ovr", 64'(o_overrun_cnt), 64'd0);
    runCycles(2);
    r = 1'b1;
    bus.out_ready = 1'b1;
    runCycles(2);
    runBasic();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
